// File: rtl/instruction_fetch.sv
// Instruction fetch front end: credit-limited sequential fetch, in-order prefetch queue, redirect flush.
// Optional perf counters (fetchCount, dropCount32, stallCycles) are enabled by defining FETCH_PERF_COUNTERS_EN.
module instruction_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  memReqValid,
  input  logic                  memReqReady,
  output logic [ADDR_WIDTH-1:0] memReqAddr,
  input  logic                  memRespValid,
  input  logic [63:0]           memRespData,
  input  logic                  redirectValid,
  input  logic [ADDR_WIDTH-1:0] redirectPc,
  input  logic                  decodeStall,
  output logic                  decodeEnable,
  output logic [63:0]           instructionData,
`ifdef FETCH_PERF_COUNTERS_EN
  output logic [31:0]           fetchCount,
  output logic [31:0]           dropCount32,
  output logic [31:0]           stallCycles,
`endif
  output logic [ADDR_WIDTH-1:0] instructionPc
);
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] fetch_pc_r, resp_pc_r, hold_pc_r, redirect_pc_s;
  logic [63:0]           q_data_r [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] q_pc_r   [QUEUE_DEPTH];
  logic [63:0]           hold_data_r;
  logic [PW-1:0]         wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]         count_r, in_flight_r, drop_cnt_r;
  logic                  credit_s, req_fire_s, resp_ok_s, drop_s, push_s, pop_s, nonempty_s;

  assign redirect_pc_s = redirectPc & ~ADDR_WIDTH'(7);
  assign nonempty_s    = (count_r != {CW{1'b0}});
  // in-flight plus buffered never exceeds the queue, so a response can always be stored
  assign credit_s      = ((in_flight_r + count_r) < CW'(QUEUE_DEPTH));
  assign memReqValid   = !reset && credit_s && !redirectValid;
  assign memReqAddr    = fetch_pc_r;
  assign req_fire_s    = memReqValid && memReqReady;
  assign resp_ok_s     = memRespValid && (in_flight_r != {CW{1'b0}});
  assign drop_s        = resp_ok_s && (drop_cnt_r != {CW{1'b0}});
  assign push_s        = resp_ok_s && (drop_cnt_r == {CW{1'b0}}) && !redirectValid;
  assign decodeEnable  = nonempty_s && !redirectValid;
  assign pop_s         = decodeEnable && !decodeStall;
  assign instructionData = nonempty_s ? q_data_r[rd_ptr_r] : hold_data_r;
  assign instructionPc   = nonempty_s ? q_pc_r[rd_ptr_r]   : hold_pc_r;

  // Fetch/response bookkeeping and queue pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_r  <= RESET_PC;
      resp_pc_r   <= RESET_PC;
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      in_flight_r <= {CW{1'b0}};
      drop_cnt_r  <= {CW{1'b0}};
    end else if (redirectValid) begin
      // every response still outstanding after this cycle belongs to the old stream
      fetch_pc_r  <= redirect_pc_s;
      resp_pc_r   <= redirect_pc_s;
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      in_flight_r <= in_flight_r - CW'(resp_ok_s);
      drop_cnt_r  <= in_flight_r - CW'(resp_ok_s);
    end else begin
      if (req_fire_s) fetch_pc_r <= fetch_pc_r + ADDR_WIDTH'(8);
      else            fetch_pc_r <= fetch_pc_r;
      if (push_s) begin
        resp_pc_r <= resp_pc_r + ADDR_WIDTH'(8);
        wr_ptr_r  <= wr_ptr_r + PW'(1);
      end else begin
        resp_pc_r <= resp_pc_r;
        wr_ptr_r  <= wr_ptr_r;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PW'(1);
      else       rd_ptr_r <= rd_ptr_r;
      if (drop_s) drop_cnt_r <= drop_cnt_r - CW'(1);
      else        drop_cnt_r <= drop_cnt_r;
      count_r     <= count_r + CW'(push_s) - CW'(pop_s);
      in_flight_r <= in_flight_r + CW'(req_fire_s) - CW'(resp_ok_s);
    end
  end

  // Queue storage
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_data_r[wr_ptr_r] <= memRespData;
      q_pc_r[wr_ptr_r]   <= resp_pc_r;
    end
  end

  // Last presented head, shown while the queue is empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_data_r <= 64'd0;
      hold_pc_r   <= RESET_PC;
    end else if (nonempty_s) begin
      hold_data_r <= q_data_r[rd_ptr_r];
      hold_pc_r   <= q_pc_r[rd_ptr_r];
    end else begin
      hold_data_r <= hold_data_r;
      hold_pc_r   <= hold_pc_r;
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  // Free-running perf counters; redirects do not clear them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetchCount  <= 32'd0;
      dropCount32 <= 32'd0;
      stallCycles <= 32'd0;
    end else begin
      fetchCount  <= fetchCount + 32'(req_fire_s);
      dropCount32 <= dropCount32 + 32'(drop_s || (resp_ok_s && redirectValid));
      stallCycles <= stallCycles + 32'(decodeEnable && decodeStall);
    end
  end
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch: bench memory plus a tagged-request queue reference model.
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic        memReqValid, memReqReady, memRespValid, redirectValid, decodeStall, decodeEnable;
  logic [31:0] memReqAddr, redirectPc, instructionPc;
  logic [63:0] memRespData, instructionData;

  instruction_fetch dut (
    .clk(clk), .reset(reset),
    .memReqValid(memReqValid), .memReqReady(memReqReady), .memReqAddr(memReqAddr),
    .memRespValid(memRespValid), .memRespData(memRespData),
    .redirectValid(redirectValid), .redirectPc(redirectPc),
    .decodeStall(decodeStall), .decodeEnable(decodeEnable),
    .instructionData(instructionData), .instructionPc(instructionPc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        stale;
    int          born;
  } req_t;

  req_t        pend[$];   // outstanding requests (memory side), tagged stale after a redirect
  logic [31:0] expq[$];   // pcs expected in the prefetch queue, oldest first
  logic [31:0] fpc;
  int          cyc;
  int          vectors = 0;
  int          fails = 0;
  logic        e_req, e_dec;
  logic [31:0] e_addr, e_pc;
  logic [63:0] e_data;

  function automatic logic [63:0] word_of(input logic [31:0] a);
    return {a ^ 32'hA5A5_0000, ~a};
  endfunction

  task automatic do_reset();
    reset = 1'b1; memReqReady = 1'b0; memRespValid = 1'b0; memRespData = 64'd0;
    redirectValid = 1'b0; redirectPc = 32'd0; decodeStall = 1'b0;
    pend.delete(); expq.delete(); fpc = 32'd0; cyc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drive one cycle of inputs (percent probabilities) and derive expected outputs from the model
  task automatic apply(input int ready_p, input int resp_p, input int stall_p,
                       input int redir_p, input logic [31:0] tgt);
    @(negedge clk);
    memReqReady   = ($urandom_range(99) < ready_p);
    decodeStall   = ($urandom_range(99) < stall_p);
    redirectValid = ($urandom_range(99) < redir_p);
    redirectPc    = tgt;
    memRespValid  = (pend.size() > 0) && (pend[0].born < cyc) && ($urandom_range(99) < resp_p);
    memRespData   = memRespValid ? word_of(pend[0].addr) : 64'hDEAD_BEEF_0BAD_F00D;
    #1;
    e_req  = !redirectValid && ((pend.size() + expq.size()) < 4);
    e_addr = fpc;
    e_dec  = (expq.size() > 0) && !redirectValid;
    e_pc   = e_dec ? expq[0] : 32'd0;
    e_data = word_of(e_pc);
  endtask

  task automatic advance();
    req_t r;
    if (e_dec && !decodeStall) void'(expq.pop_front());
    if (memRespValid) begin
      r = pend.pop_front();
      if (!r.stale && !redirectValid) expq.push_back(r.addr);
    end
    if (redirectValid) begin
      expq.delete();
      for (int i = 0; i < pend.size(); i++) begin
        r = pend[i]; r.stale = 1'b1; pend[i] = r;
      end
      fpc = redirectPc & ~32'd7;
    end else if (e_req && memReqReady) begin
      pend.push_back('{addr: fpc, stale: 1'b0, born: cyc});
      fpc = fpc + 32'd8;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    #1;
    vectors += 4;
    if (memReqValid !== 1'b0) begin fails++; $display("FAIL reset_req got %b want 0", memReqValid); end
    if (decodeEnable !== 1'b0) begin fails++; $display("FAIL reset_dec got %b want 0", decodeEnable); end
    if (instructionData !== 64'd0) begin fails++; $display("FAIL reset_data got %h want 0", instructionData); end
    if (instructionPc !== 32'd0) begin fails++; $display("FAIL reset_pc got %h want 0", instructionPc); end
  endtask

  task automatic test_stream();
    int first_dec;
    do_reset();
    first_dec = -1;
    for (int i = 0; i < 30; i++) begin
      apply(100, 100, 0, 0, 32'd0);
      vectors += 2;
      if (memReqValid !== e_req || (e_req && memReqAddr !== e_addr)) begin
        fails++; $display("FAIL stream_req cyc %0d got %b/%h want %b/%h", cyc, memReqValid, memReqAddr, e_req, e_addr);
      end
      if (decodeEnable !== e_dec || (e_dec && {instructionPc, instructionData} !== {e_pc, e_data})) begin
        fails++; $display("FAIL stream_dec cyc %0d got %b/%h/%h want %b/%h/%h", cyc, decodeEnable, instructionPc, instructionData, e_dec, e_pc, e_data);
      end
      if (first_dec < 0 && decodeEnable === 1'b1) first_dec = cyc;
      advance();
    end
    // request in cycle 0, response in cycle 1, visible to decode in cycle 2
    vectors++;
    if (first_dec != 2) begin fails++; $display("FAIL stream_latency got %0d want 2", first_dec); end
  endtask

  task automatic test_backpressure();
    int issued;
    do_reset();
    issued = 0;
    for (int i = 0; i < 16; i++) begin
      apply(100, 100, (i < 10) ? 100 : 0, 0, 32'd0);
      vectors += 2;
      if (memReqValid !== e_req || (e_req && memReqAddr !== e_addr)) begin
        fails++; $display("FAIL bp_req cyc %0d got %b/%h want %b/%h", cyc, memReqValid, memReqAddr, e_req, e_addr);
      end
      if (decodeEnable !== e_dec || (e_dec && {instructionPc, instructionData} !== {e_pc, e_data})) begin
        fails++; $display("FAIL bp_dec cyc %0d got %b/%h want %b/%h", cyc, decodeEnable, instructionPc, e_dec, e_pc);
      end
      if (i < 10 && memReqValid === 1'b1 && memReqReady === 1'b1) issued++;
      advance();
    end
    vectors++;
    if (issued != 4) begin fails++; $display("FAIL bp_issued got %0d want 4", issued); end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 28; i++) begin
      // 3 requests stay in flight, then redirect; later a redirect collides with a response and a pop
      if (i < 3)        apply(100, 0, 0, 0, 32'd0);
      else if (i == 3)  apply(0, 0, 0, 100, 32'h0000_1007);
      else if (i == 14) apply(100, 100, 0, 100, 32'hFFFF_FFF3);
      else              apply(100, 100, 0, 0, 32'd0);
      vectors += 2;
      if (memReqValid !== e_req || (e_req && memReqAddr !== e_addr)) begin
        fails++; $display("FAIL redir_req cyc %0d got %b/%h want %b/%h", cyc, memReqValid, memReqAddr, e_req, e_addr);
      end
      if (decodeEnable !== e_dec || (e_dec && {instructionPc, instructionData} !== {e_pc, e_data})) begin
        fails++; $display("FAIL redir_dec cyc %0d got %b/%h want %b/%h", cyc, decodeEnable, instructionPc, e_dec, e_pc);
      end
      advance();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      apply(70, 60, 30, 5, $urandom);
      vectors += 2;
      if (memReqValid !== e_req || (e_req && memReqAddr !== e_addr)) begin
        fails++; $display("FAIL rand_req cyc %0d got %b/%h want %b/%h", cyc, memReqValid, memReqAddr, e_req, e_addr);
      end
      if (decodeEnable !== e_dec || (e_dec && {instructionPc, instructionData} !== {e_pc, e_data})) begin
        fails++; $display("FAIL rand_dec cyc %0d got %b/%h/%h want %b/%h/%h", cyc, decodeEnable, instructionPc, instructionData, e_dec, e_pc, e_data);
      end
      advance();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(100, 100, 100, 0, 32'd0);
      advance();
    end
    @(negedge clk);
    memRespValid = 1'b0; redirectValid = 1'b0;
    #2 reset = 1'b1;
    #1;
    vectors += 4;
    if (memReqValid !== 1'b0) begin fails++; $display("FAIL areset_req got %b want 0", memReqValid); end
    if (decodeEnable !== 1'b0) begin fails++; $display("FAIL areset_dec got %b want 0", decodeEnable); end
    if (instructionData !== 64'd0) begin fails++; $display("FAIL areset_data got %h want 0", instructionData); end
    if (instructionPc !== 32'd0) begin fails++; $display("FAIL areset_pc got %h want 0", instructionPc); end
    do_reset();
    for (int i = 0; i < 12; i++) begin
      apply(100, 100, 0, 0, 32'd0);
      vectors += 2;
      if (memReqValid !== e_req || (e_req && memReqAddr !== e_addr)) begin
        fails++; $display("FAIL areset_restart_req cyc %0d got %b/%h want %b/%h", cyc, memReqValid, memReqAddr, e_req, e_addr);
      end
      if (decodeEnable !== e_dec || (e_dec && {instructionPc, instructionData} !== {e_pc, e_data})) begin
        fails++; $display("FAIL areset_restart_dec cyc %0d got %b/%h want %b/%h", cyc, decodeEnable, instructionPc, e_dec, e_pc);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
